// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch redirect sequencer: turns an accepted taken branch into a PC
// redirect plus pipeline flushes, holds it across fetch stalls, and keeps stats.
module branch_redirect_ctrl #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              PcSel,
  input  logic [31:0]       BrPC,
  input  logic              hazard_stall,
  input  logic              fetch_stall,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              pc_hold,
  output logic [CNT_W-1:0]  br_taken_cnt,
  output logic [CNT_W-1:0]  redirect_stall_cnt,
  output logic              misalign_err
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next_state;
  logic [PC_W-1:0]   r_target;
  logic [CNT_W-1:0]  r_br_taken_cnt;
  logic [CNT_W-1:0]  r_redirect_stall_cnt;
  logic              r_misalign_err;

  logic              w_trigger;
  logic              w_aligned;
  logic              w_accept;
  logic              w_misalign;
  logic              w_stall_event;
  logic              w_unused_brpc_hi;

  assign w_trigger        = ex_valid && PcSel;
  assign w_aligned        = (BrPC[1:0] == 2'b00);
  // Triggers only matter in IDLE; in PENDING the EX stage carries wrong-path bubbles.
  assign w_accept         = (r_state == ST_IDLE) && w_trigger && w_aligned;
  assign w_misalign       = (r_state == ST_IDLE) && w_trigger && !w_aligned;
  assign w_stall_event    = redirect_valid && fetch_stall;
  assign w_unused_brpc_hi = ^BrPC[31:PC_W];

  // State register and redirect target latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_target <= {PC_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_target <= BrPC[PC_W-1:0];
      end else begin
        r_target <= r_target;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && fetch_stall) begin
          w_next_state = ST_PENDING;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (!fetch_stall) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_PENDING;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic; everything is forced low during a reset cycle.
  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = {PC_W{1'b0}};
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    pc_hold        = 1'b0;
    if (reset) begin
      redirect_valid = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            redirect_valid = 1'b1;
            redirect_pc    = BrPC[PC_W-1:0];
            flush_if_id    = 1'b1;
            flush_id_ex    = 1'b1;
          end else begin
            redirect_valid = 1'b0;
          end
        end
        ST_PENDING: begin
          redirect_valid = 1'b1;
          redirect_pc    = r_target;
          flush_if_id    = 1'b1;
          flush_id_ex    = 1'b1;
        end
        default: redirect_valid = 1'b0;
      endcase
      // A redirect wins over a load-use stall: the stalled instruction is wrong-path.
      pc_hold = hazard_stall && !redirect_valid;
    end
  end

  // Saturating statistics counters and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_taken_cnt       <= {CNT_W{1'b0}};
      r_redirect_stall_cnt <= {CNT_W{1'b0}};
      r_misalign_err       <= 1'b0;
    end else begin
      if (w_accept && (r_br_taken_cnt != CNT_MAX)) begin
        r_br_taken_cnt <= r_br_taken_cnt + CNT_ONE;
      end else begin
        r_br_taken_cnt <= r_br_taken_cnt;
      end
      if (w_stall_event && (r_redirect_stall_cnt != CNT_MAX)) begin
        r_redirect_stall_cnt <= r_redirect_stall_cnt + CNT_ONE;
      end else begin
        r_redirect_stall_cnt <= r_redirect_stall_cnt;
      end
      if (w_misalign) begin
        r_misalign_err <= 1'b1;
      end else begin
        r_misalign_err <= r_misalign_err;
      end
    end
  end

  assign br_taken_cnt       = r_br_taken_cnt;
  assign redirect_stall_cnt = r_redirect_stall_cnt;
  assign misalign_err       = r_misalign_err;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl with hand-computed expectations.
module tb_branch_redirect_ctrl;

  localparam int PC_W  = 9;
  localparam int CNT_W = 16;

  logic              clk;
  logic              reset;
  logic              ex_valid;
  logic              PcSel;
  logic [31:0]       BrPC;
  logic              hazard_stall;
  logic              fetch_stall;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              pc_hold;
  logic [CNT_W-1:0]  br_taken_cnt;
  logic [CNT_W-1:0]  redirect_stall_cnt;
  logic              misalign_err;

  int n_checks;
  int n_errs;

  branch_redirect_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .ex_valid           (ex_valid),
    .PcSel              (PcSel),
    .BrPC               (BrPC),
    .hazard_stall       (hazard_stall),
    .fetch_stall        (fetch_stall),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .flush_if_id        (flush_if_id),
    .flush_id_ex        (flush_id_ex),
    .pc_hold            (pc_hold),
    .br_taken_cnt       (br_taken_cnt),
    .redirect_stall_cnt (redirect_stall_cnt),
    .misalign_err       (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic rv, input logic [31:0] pc,
                           input logic fl, input logic ph, input logic [31:0] btc,
                           input logic [31:0] rsc, input logic me);
    check_val({tag, ".redirect_valid"},     {31'd0, redirect_valid}, {31'd0, rv});
    check_val({tag, ".redirect_pc"},        {23'd0, redirect_pc},    pc);
    check_val({tag, ".flush_if_id"},        {31'd0, flush_if_id},    {31'd0, fl});
    check_val({tag, ".flush_id_ex"},        {31'd0, flush_id_ex},    {31'd0, fl});
    check_val({tag, ".pc_hold"},            {31'd0, pc_hold},        {31'd0, ph});
    check_val({tag, ".br_taken_cnt"},       {16'd0, br_taken_cnt},   btc);
    check_val({tag, ".redirect_stall_cnt"}, {16'd0, redirect_stall_cnt}, rsc);
    check_val({tag, ".misalign_err"},       {31'd0, misalign_err},   {31'd0, me});
  endtask

  // Advance one clock; inputs are then changed just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic ps, input logic [31:0] pc,
                       input logic hz, input logic fs);
    ex_valid     = ev;
    PcSel        = ps;
    BrPC         = pc;
    hazard_stall = hz;
    fetch_stall  = fs;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    reset    = 1'b1;
    ex_valid = 1'b0; PcSel = 1'b0; BrPC = 32'd0; hazard_stall = 1'b0; fetch_stall = 1'b0;

    // Reset with an active trigger and stall: outputs forced low.
    tick();
    drive(1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b1);
    check_all("rst_forced", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      check_all("idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick();
    end

    // Simple redirect, fetch ready.
    drive(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    check_all("redir", 1'b1, 32'h040, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check_all("redir_after", 1'b0, 32'h0, 1'b0, 1'b0, 32'd1, 32'd0, 1'b0);
    tick();

    // Redirect held across three fetch-stall cycles; a later trigger to 0x80 is ignored.
    drive(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b1);
    check_all("hold0", 1'b1, 32'h040, 1'b1, 1'b0, 32'd1, 32'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
    check_all("hold1", 1'b1, 32'h040, 1'b1, 1'b0, 32'd2, 32'd1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
    check_all("hold2", 1'b1, 32'h040, 1'b1, 1'b0, 32'd2, 32'd2, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
    check_all("hold3", 1'b1, 32'h040, 1'b1, 1'b0, 32'd2, 32'd3, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check_all("hold_done", 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, 32'd3, 1'b0);
    tick();

    // Load-use stall alone, then overridden by a redirect.
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_all("hz_only", 1'b0, 32'h0, 1'b0, 1'b1, 32'd2, 32'd3, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_0010, 1'b1, 1'b0);
    check_all("hz_redir", 1'b1, 32'h010, 1'b1, 1'b0, 32'd2, 32'd3, 1'b0);
    tick();

    // Upper target bits are dropped.
    drive(1'b1, 1'b1, 32'hABCD_E1FC, 1'b0, 1'b0);
    check_all("upper_bits", 1'b1, 32'h1FC, 1'b1, 1'b0, 32'd3, 32'd3, 1'b0);
    tick();

    // Misaligned target: no redirect, stall still honoured, sticky error.
    drive(1'b1, 1'b1, 32'h0000_0042, 1'b1, 1'b0);
    check_all("misalign", 1'b0, 32'h0, 1'b0, 1'b1, 32'd4, 32'd3, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      check_all("misalign_sticky", 1'b0, 32'h0, 1'b0, 1'b0, 32'd4, 32'd3, 1'b1);
      tick();
    end

    // Reset in the middle of a pending redirect.
    drive(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
    check_all("pend_enter", 1'b1, 32'h100, 1'b1, 1'b0, 32'd4, 32'd3, 1'b1);
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check_val("rst_pend.redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check_val("rst_pend.flush_if_id",    {31'd0, flush_if_id},    32'd0);
    check_val("rst_pend.pc_hold",        {31'd0, pc_hold},        32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_all("post_rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();

    // Saturation of the taken-branch counter with back-to-back triggers.
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, 1'b1, 32'h0000_0020, 1'b0, 1'b0);
      tick();
      if (i == 65533) begin
        check_val("sat_near", {16'd0, br_taken_cnt}, 32'h0000_FFFE);
      end
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check_all("sat", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_FFFF, 32'd0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencing controller for the EX-stage branch unit. It turns a taken branch or jump (`PcSel`, `BrPC`) into a PC redirect for the fetch stage and flushes the IF/ID and ID/EX pipeline registers. If fetch cannot accept the new PC, it holds the target until fetch accepts it. It sits between the branch unit, the hazard unit and the PC register, and keeps saturating branch statistics plus a sticky misaligned-target error flag.

## Interface
Parameters:
- `PC_W`, 9, width of the architectural PC; must match the branch unit.
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  EX stage holds a valid, non-bubble instruction.
- `PcSel`  in  1  branch unit: branch/jump taken.
- `BrPC`  in  32  branch unit: redirect target.
- `hazard_stall`  in  1  hazard unit load-use stall request.
- `fetch_stall`  in  1  fetch/IMEM cannot accept a new PC this cycle.
- `redirect_valid`  out  1  load `redirect_pc` into PC this cycle.
- `redirect_pc`  out  PC_W  redirect target.
- `flush_if_id`  out  1  clear IF/ID at next edge.
- `flush_id_ex`  out  1  clear ID/EX at next edge.
- `pc_hold`  out  1  freeze PC and IF/ID (stall).
- `br_taken_cnt`  out  CNT_W  accepted taken-branch count, saturating.
- `redirect_stall_cnt`  out  CNT_W  cycles spent with a redirect blocked by `fetch_stall`, saturating.
- `misalign_err`  out  1  sticky: a taken target had `BrPC[1:0] != 0`.

## Operation
- A trigger is `ex_valid && PcSel`. It is accepted only when its target is aligned (`BrPC[1:0] == 2'b00`).
- FSM states: IDLE, PENDING. Reset state is IDLE.
- IDLE, accepted trigger:
  - `redirect_valid=1`, `redirect_pc=BrPC[PC_W-1:0]`, `flush_if_id=1`, `flush_id_ex=1`, all combinational in the same cycle.
  - Latch `BrPC[PC_W-1:0]` into the target register.
  - If `fetch_stall=1`, go to PENDING; otherwise stay in IDLE.
- IDLE, misaligned trigger: no redirect, no flush, no count. Set `misalign_err` at the edge.
- IDLE, no trigger: all control outputs are 0 except `pc_hold=hazard_stall`.
- PENDING:
  - `redirect_valid=1` with the latched target. `flush_if_id=1` and `flush_id_ex=1` every cycle.
  - Any trigger is ignored (EX holds wrong-path bubbles).
  - Return to IDLE at the edge of the first cycle with `fetch_stall=0`; that cycle is the acceptance.
- `pc_hold = hazard_stall && !redirect_valid`. A redirect overrides a load-use stall because the stalled instruction is on the wrong path.
- `br_taken_cnt` increments by 1 at the edge ending each accepted IDLE trigger. It saturates at all-ones.
- `redirect_stall_cnt` increments at each edge where `redirect_valid && fetch_stall`, in either state. It saturates at all-ones.
- Only `BrPC[PC_W-1:0]` drives `redirect_pc`; upper bits are ignored.
- `reset` has priority over every input, including reset mid-PENDING:
  - FSM goes to IDLE and the target register clears to 0.
  - Counters clear to 0 and `misalign_err` clears to 0.
  - During a reset cycle all combinational outputs are forced to 0.

## Timing
- Reset values: `redirect_valid=0`, `redirect_pc=0`, both flushes 0, `pc_hold=0`, counters 0, `misalign_err=0`.
- Redirect latency is 0 cycles: the trigger cycle drives the redirect and flushes, and PC holds the target after the next edge.
- With fetch stalled, the redirect is held for N+1 cycles, where N is the number of consecutive `fetch_stall=1` cycles starting at the trigger. The flushes are asserted for all of those cycles.
- Back-to-back triggers in IDLE on consecutive cycles are each accepted and counted. In practice the pipeline does not produce them because the flush creates bubbles.
- `misalign_err` and the counters are registered and update one edge after the causing cycle.

## Test plan
- Reset, then idle for 3 cycles → all outputs 0; assert `reset` mid-PENDING → next cycle IDLE, `redirect_valid=0`, counters 0.
- `ex_valid=1`, `PcSel=1`, `BrPC=0x0000_0040`, `fetch_stall=0` → same cycle `redirect_valid=1`, `redirect_pc=0x040`, both flushes 1; next cycle all 0; `br_taken_cnt=1`.
- Same trigger with `fetch_stall=1` for 3 cycles → `redirect_valid=1` and `redirect_pc=0x040` for 4 cycles while `BrPC` changes to 0x80 and a second trigger is ignored; `redirect_stall_cnt=3`, `br_taken_cnt=1`.
- `hazard_stall=1` with no trigger → `pc_hold=1`; `hazard_stall=1` with trigger `BrPC=0x10` → `pc_hold=0`, `redirect_valid=1`.
- Trigger with `BrPC=0x0000_0042` → no redirect, no flush; `misalign_err=1` from next cycle and held until reset.
- Saturation: run 65,540 accepted triggers (`CNT_W=16`) → `br_taken_cnt=0xFFFF`, no wrap.
